// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle for seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU, one request in flight; SEQ_ALU_MULDIV_EN enables iterative mul/div
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [1:0] S_BUSY = 2'd1;
`endif
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
`endif
  localparam logic [2:0] OP_CMP = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] fast_res;
  logic             fast_carry;

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Mul: {partial high, multiplier shifting out}; div: {remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
`endif

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

  // Single-cycle result straight from the request inputs; mul/div land in default when the iterative path is absent
  always_comb begin
    add_sum    = {1'b0, bus.a} + {1'b0, bus.b};
    fast_res   = '0;
    fast_carry = 1'b0;
    case (bus.op)
      OP_ADD: begin
        fast_res   = add_sum[WIDTH-1:0];
        fast_carry = add_sum[WIDTH];
      end
      OP_SUB: begin
        fast_res   = bus.a - bus.b;
        fast_carry = (bus.a < bus.b);
      end
      OP_AND:  fast_res = bus.a & bus.b;
      OP_OR:   fast_res = bus.a | bus.b;
      OP_XOR:  fast_res = bus.a ^ bus.b;
      OP_CMP:  fast_res = (bus.a == bus.b) ? WIDTH'(1) : '0;
      default: begin
        fast_res   = '0;
        fast_carry = 1'b1;
      end
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // One shift-add multiply step and one restoring-divide step per BUSY cycle
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Next-state: accept in IDLE, iterate in BUSY, hold the result in DONE until the consumer takes it
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
`ifdef SEQ_ALU_MULDIV_EN
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (bus.op == OP_MUL || bus.op == OP_DIV) begin
            state_d = S_BUSY;
            op_d    = bus.op;
            a_d     = bus.a;
            b_d     = bus.b;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, (bus.op == OP_MUL) ? bus.b : bus.a};
          end else
`endif
          begin
            state_d  = S_DONE;
            result_d = fast_res;
            carry_d  = fast_carry;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_BUSY: begin
        acc_d = (op_q == OP_MUL) ? mul_step : div_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          if (op_q == OP_MUL) begin
            result_d = mul_step[WIDTH-1:0];
            carry_d  = |mul_step[2*WIDTH-1:WIDTH];
          end else if (b_q == '0) begin
            result_d = '0;
            carry_d  = 1'b1;
          end else begin
            result_d = div_step[WIDTH-1:0];
            carry_d  = 1'b0;
          end
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
`ifdef SEQ_ALU_MULDIV_EN
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed bench for seq_alu against a behavioural model
module tb_seq_alu;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 idle, 1 computing, 2 result presented
  int         m_state = 0;
  int         m_wait  = 0;
  int         m_lat   = 1;
  logic [7:0] m_res;
  logic       m_c;
  logic [7:0] m_last   = 8'h00;
  logic       m_last_c = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the block must produce for one request, from plain integer arithmetic
  function automatic void ref_op(input logic [2:0] o, input int x, input int y,
                                 output logic [7:0] r, output logic c, output int lat);
    int t;
    r   = 8'h00;
    c   = 1'b0;
    lat = 1;
    case (o)
      3'd0: begin t = x + y; r = t[7:0]; c = (t > 255); end
      3'd1: begin t = x - y; r = t[7:0]; c = (x < y); end
      3'd2: begin t = x & y; r = t[7:0]; end
      3'd3: begin t = x | y; r = t[7:0]; end
      3'd4: begin t = x ^ y; r = t[7:0]; end
`ifdef SEQ_ALU_MULDIV_EN
      3'd5: begin t = x * y; r = t[7:0]; c = (t > 255); lat = W + 1; end
      3'd6: begin
        lat = W + 1;
        if (y == 0) begin r = 8'h00; c = 1'b1; end
        else begin t = x / y; r = t[7:0]; end
      end
`else
      3'd5: begin r = 8'h00; c = 1'b1; end
      3'd6: begin r = 8'h00; c = 1'b1; end
`endif
      default: r = (x == y) ? 8'd1 : 8'd0;
    endcase
  endfunction

  // Cycle model: follows the handshake rules using the stimulus seen at each rising edge
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state  = 0;
        m_last   = 8'h00;
        m_last_c = 1'b0;
      end else begin
        case (m_state)
          0: if (bus.in_valid) begin
            ref_op(bus.op, int'(bus.a), int'(bus.b), m_res, m_c, m_lat);
            if (m_lat == 1) begin
              m_state = 2; m_last = m_res; m_last_c = m_c;
            end else begin
              m_state = 1; m_wait = m_lat - 1;
            end
          end
          1: begin
            m_wait--;
            if (m_wait == 0) begin
              m_state = 2; m_last = m_res; m_last_c = m_c;
            end
          end
          default: if (bus.out_ready) m_state = 0;
        endcase
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(bus.in_ready), 32'(m_state == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_state == 2));
      chk("result", 32'(bus.result), 32'(m_last));
      chk("carry_out", 32'(bus.carry_out), 32'(m_last_c));
    end
  end

  function automatic logic [7:0] pick();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'h00;
    if (s == 1) return 8'hFF;
    if (s == 2) return 8'h01;
    return 8'($urandom_range(0, 255));
  endfunction

  // Issue one request (called at a negedge with the DUT idle), wait for the result, hold it for
  // 'stall' extra cycles, then complete; literal expectations are checked when 'lit' is set.
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input int stall, input bit lit, input logic [7:0] lres,
                       input logic lc, input int llat);
    int lat;
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.a         = x;
    bus.b         = y;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op       = 3'($urandom_range(0, 7));
    bus.a        = 8'($urandom_range(0, 255));
    bus.b        = 8'($urandom_range(0, 255));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    if (!bus.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: op %0d no out_valid after %0d cycles", o, lat);
    end else if (lit) begin
      chk("lit_latency", 32'(lat), 32'(llat));
      chk("lit_result", 32'(bus.result), 32'(lres));
      chk("lit_carry", 32'(bus.carry_out), 32'(lc));
    end
    for (int s = 1; s < stall; s++) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    logic       c;
    int         l;
    logic [2:0] ro;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;

    // pin the model to hand-computed values
    ref_op(3'd0, 200, 100, r, c, l);
    chk("model_add", {23'd0, c, r}, {23'd0, 1'b1, 8'h2C});
    ref_op(3'd1, 5, 10, r, c, l);
    chk("model_sub", {23'd0, c, r}, {23'd0, 1'b1, 8'hFB});
    ref_op(3'd5, 20, 15, r, c, l);
`ifdef SEQ_ALU_MULDIV_EN
    chk("model_mul", {23'd0, c, r}, {23'd0, 1'b1, 8'h2C});
    chk("model_mul_lat", 32'(l), 32'd9);
`else
    chk("model_mul", {23'd0, c, r}, {23'd0, 1'b1, 8'h00});
`endif

    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.carry_out), 32'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd0, 8'd200, 8'd100, 0, 1'b1, 8'h2C, 1'b1, 1);
    do_op(3'd1, 8'd5, 8'd10, 0, 1'b1, 8'hFB, 1'b1, 1);
    do_op(3'd7, 8'h5A, 8'h5A, 0, 1'b1, 8'h01, 1'b0, 1);
`ifdef SEQ_ALU_MULDIV_EN
    do_op(3'd5, 8'd20, 8'd15, 0, 1'b1, 8'h2C, 1'b1, 9);
    do_op(3'd6, 8'd100, 8'd7, 0, 1'b1, 8'd14, 1'b0, 9);
    do_op(3'd6, 8'd55, 8'd0, 0, 1'b1, 8'h00, 1'b1, 9);
`else
    do_op(3'd5, 8'd20, 8'd15, 0, 1'b1, 8'h00, 1'b1, 1);
    do_op(3'd6, 8'd100, 8'd7, 0, 1'b1, 8'h00, 1'b1, 1);
    do_op(3'd6, 8'd55, 8'd0, 0, 1'b1, 8'h00, 1'b1, 1);
`endif
    do_op(3'd4, 8'hF0, 8'h3C, 3, 1'b1, 8'hCC, 1'b0, 1);

    // reset four cycles into a long multiply
    bus.in_valid  = 1'b1;
    bus.op        = 3'd5;
    bus.a         = 8'd255;
    bus.b         = 8'd255;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_carry", 32'(bus.carry_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(3'd0, 8'd1, 8'd1, 0, 1'b1, 8'd2, 1'b0, 1);

    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      do_op(ro, pick(), pick(), $urandom_range(0, 3), 1'b0, 8'h00, 1'b0, 0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
